// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// read/write polarity of the RW strobe and the default wait-state count.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_W word store with one write port and a registered read port.
// Only the read register is reset; the stored words survive reset.
module mem_resp_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
    end

    // The read register doubles as the responder's data_out holding register.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem_array[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the EN/RW/address/MFC four-phase handshake, with
// programmable wait states and a side-band preload port sharing the array.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              MFC,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    // Upper address bits are discarded by reducing modulo DEPTH.
    function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] a);
        logic [63:0] wide;
        wide = 64'(a);
        return IDX_W'(wide % 64'(DEPTH));
    endfunction

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              rw_reg;
    logic [IDX_W-1:0]  addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              mfc_reg;
    logic              ld_ack_reg;

    logic              access_now;
    logic              bus_wr;
    logic              bus_rd;
    logic              ld_wr;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Writes are gated by rst so an aborted-by-reset request never commits.
    assign access_now = (state_reg == BUSY) && EN && (cnt_reg == '0) && !rst;
    assign bus_wr     = access_now && (rw_reg == RW_WRITE);
    assign bus_rd     = access_now && (rw_reg == RW_READ);
    assign ld_wr      = (state_reg == IDLE) && !EN && ld_en && !rst;

    assign mem_we    = bus_wr || ld_wr;
    assign mem_waddr = bus_wr ? addr_reg : to_index(ld_addr);
    assign mem_wdata = bus_wr ? data_reg : ld_data;

    mem_resp_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .srst  (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (bus_rd),
        .raddr (addr_reg),
        .rdata (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rw_reg     <= 1'b0;
            addr_reg   <= '0;
            data_reg   <= '0;
            mfc_reg    <= 1'b0;
            ld_ack_reg <= 1'b0;
        end else begin
            ld_ack_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (EN) begin
                        rw_reg    <= RW;
                        addr_reg  <= to_index(address);
                        data_reg  <= data_in;
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= BUSY;
                    end else if (ld_en) begin
                        ld_ack_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!EN) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        mfc_reg   <= 1'b1;
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    if (!EN) begin
                        mfc_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    mfc_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign MFC    = mfc_reg;
    assign ld_ack = ld_ack_reg;

endmodule
